// File: rtl/elevator_pkg.sv
// Shared elevator definitions: car state encoding, direction constants and
// default floor geometry used by the controller, display and car sequencer.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } car_state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEFAULT_NUM_FLOORS = 8;
    localparam int DEFAULT_FLOOR_W    = 3;

    // Width needed to hold values up to max(a, b) - 1, never narrower than one bit.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m <= 2) begin
            return 1;
        end else begin
            return $clog2(m);
        end
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that parks at zero; shared by the travel and dwell phases.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Count register: load has priority, otherwise decrement until zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != {W{1'b0}}) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/car_motion_sequencer.sv
// Steps the elevator car floor by floor toward the latched target, then dwells
// with the door open. Optional door-hold input enabled by CAR_DOOR_HOLD_EN.
module car_motion_sequencer
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = DEFAULT_NUM_FLOORS,
    parameter int FLOOR_W       = DEFAULT_FLOOR_W,
    parameter int TRAVEL_CYCLES = 50,
    parameter int DOOR_CYCLES   = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOOR_W-1:0] target_floor,
    input  logic               target_valid,
`ifdef CAR_DOOR_HOLD_EN
    input  logic               door_hold,
`endif
    output logic [FLOOR_W-1:0] current_floor,
    output logic               direction,
    output logic               moving,
    output logic               door_open,
    output logic               arrived,
    output logic               busy
);

    localparam int TW = timer_width(TRAVEL_CYCLES, DOOR_CYCLES);
    localparam logic [TW-1:0]    TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0]    DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W:0] FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

    car_state_e         state_r;
    logic [FLOOR_W-1:0] current_floor_r;
    logic [FLOOR_W-1:0] target_r;
    logic               direction_r;
    logic               moving_r;
    logic               door_open_r;
    logic               arrived_r;
    logic               busy_r;

    logic               in_range_s;
    logic               ahead_s;
    logic               retarget_s;
    logic               arrive_s;
    logic               hold_s;
    logic               timer_zero_s;
    logic               load_s;
    logic [TW-1:0]      load_value_s;
    logic [FLOOR_W-1:0] next_floor_s;
    logic [FLOOR_W-1:0] eff_target_s;

`ifdef CAR_DOOR_HOLD_EN
    assign hold_s = door_hold;
`else
    assign hold_s = 1'b0;
`endif

    assign in_range_s   = ({1'b0, target_floor} < FLOOR_LIMIT);
    assign next_floor_s = direction_r ? (current_floor_r + FLOOR_W'(1))
                                      : (current_floor_r - FLOOR_W'(1));

    cycle_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .load_value (load_value_s),
        .zero       (timer_zero_s)
    );

    // Next-step decode: retarget acceptance, arrival compare and timer reloads.
    always_comb begin
        ahead_s      = 1'b0;
        retarget_s   = 1'b0;
        eff_target_s = target_r;
        arrive_s     = 1'b0;
        load_s       = 1'b0;
        load_value_s = {TW{1'b0}};
        case (state_r)
            IDLE: begin
                if (target_valid && in_range_s) begin
                    load_s = 1'b1;
                    if (target_floor == current_floor_r) begin
                        load_value_s = DOOR_LOAD;
                    end else begin
                        load_value_s = TRAVEL_LOAD;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            MOVE: begin
                if (direction_r == DIR_UP) begin
                    ahead_s = (target_floor > current_floor_r);
                end else begin
                    ahead_s = (target_floor < current_floor_r);
                end
                // A retarget coinciding with a floor step is compared immediately.
                if (target_valid && in_range_s && ahead_s) begin
                    retarget_s   = 1'b1;
                    eff_target_s = target_floor;
                end else begin
                    retarget_s   = 1'b0;
                end
                if (timer_zero_s) begin
                    arrive_s     = (next_floor_s == eff_target_s);
                    load_s       = 1'b1;
                    load_value_s = arrive_s ? DOOR_LOAD : TRAVEL_LOAD;
                end else begin
                    load_s = 1'b0;
                end
            end
            DOOR: begin
                if (hold_s) begin
                    load_s       = 1'b1;
                    load_value_s = DOOR_LOAD;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Car state machine with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            current_floor_r <= {FLOOR_W{1'b0}};
            target_r        <= {FLOOR_W{1'b0}};
            direction_r     <= DIR_UP;
            moving_r        <= 1'b0;
            door_open_r     <= 1'b0;
            arrived_r       <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            arrived_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (target_valid && in_range_s) begin
                        busy_r <= 1'b1;
                        if (target_floor == current_floor_r) begin
                            state_r     <= DOOR;
                            door_open_r <= 1'b1;
                            arrived_r   <= 1'b1;
                        end else begin
                            state_r     <= MOVE;
                            moving_r    <= 1'b1;
                            target_r    <= target_floor;
                            direction_r <= (target_floor > current_floor_r) ? DIR_UP : DIR_DOWN;
                        end
                    end
                end
                MOVE: begin
                    if (retarget_s) begin
                        target_r <= target_floor;
                    end
                    if (timer_zero_s) begin
                        current_floor_r <= next_floor_s;
                        if (arrive_s) begin
                            state_r     <= DOOR;
                            moving_r    <= 1'b0;
                            door_open_r <= 1'b1;
                            arrived_r   <= 1'b1;
                        end
                    end
                end
                DOOR: begin
                    if (timer_zero_s && !hold_s) begin
                        state_r     <= IDLE;
                        door_open_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    moving_r    <= 1'b0;
                    door_open_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign current_floor = current_floor_r;
    assign direction     = direction_r;
    assign moving        = moving_r;
    assign door_open     = door_open_r;
    assign arrived       = arrived_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_car_motion_sequencer.sv
// Directed self-checking bench for car_motion_sequencer (TRAVEL=4, DOOR=6).
// Door-hold scenario runs only when CAR_DOOR_HOLD_EN is defined.
module tb_car_motion_sequencer;

    localparam int TRAVEL = 4;
    localparam int DWELL  = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] target_floor;
    logic       target_valid;
    logic       door_hold;
    logic [2:0] current_floor;
    logic       direction, moving, door_open, arrived, busy;

    logic [2:0] t6_floor;
    logic       t6_valid;
    logic [2:0] c6_floor;
    logic       d6_dir, d6_moving, d6_door, d6_arrived, d6_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    car_motion_sequencer #(.NUM_FLOORS(8), .FLOOR_W(3), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DWELL)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .target_floor  (target_floor),
        .target_valid  (target_valid),
`ifdef CAR_DOOR_HOLD_EN
        .door_hold     (door_hold),
`endif
        .current_floor (current_floor),
        .direction     (direction),
        .moving        (moving),
        .door_open     (door_open),
        .arrived       (arrived),
        .busy          (busy)
    );

    car_motion_sequencer #(.NUM_FLOORS(6), .FLOOR_W(3), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DWELL)) u_dut6 (
        .clk           (clk),
        .reset         (reset),
        .target_floor  (t6_floor),
        .target_valid  (t6_valid),
`ifdef CAR_DOOR_HOLD_EN
        .door_hold     (1'b0),
`endif
        .current_floor (c6_floor),
        .direction     (d6_dir),
        .moving        (d6_moving),
        .door_open     (d6_door),
        .arrived       (d6_arrived),
        .busy          (d6_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(input logic [2:0] t);
        target_floor = t;
        target_valid = 1'b1;
        tick(1);
        target_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 200; i++) begin
            if (!busy) break;
            tick(1);
        end
        check(tag, (i < 200) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        int cnt;
        int arr_cnt;
        int bad;
        reset        = 1'b1;
        target_floor = 3'd0;
        target_valid = 1'b0;
        door_hold    = 1'b0;
        t6_floor     = 3'd0;
        t6_valid     = 1'b0;
        tick(2);
        reset = 1'b0;
        check("rst_floor", current_floor, 0);
        check("rst_dir", direction, 1);
        check("rst_flags", {moving, door_open, arrived, busy}, 0);

        // Basic move 0 -> 3
        go(3'd3);
        check("mv_start", {moving, busy, direction}, 3'b111);
        check("mv_floor0", current_floor, 0);
        for (int f = 1; f <= 3; f++) begin
            tick(TRAVEL - 1);
            check("mv_hold_floor", current_floor, f - 1);
            tick(1);
            check("mv_step_floor", current_floor, f);
        end
        check("mv_arrive", {arrived, moving, door_open}, 3'b101);
        cnt = 1;
        arr_cnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (arrived) arr_cnt++;
            if (door_open) cnt++;
            else break;
        end
        check("door_len", cnt, DWELL);
        check("arr_once", arr_cnt, 1);
        check("mv_idle", {busy, door_open}, 0);

        // Reset while moving down past floor 2
        go(3'd0);
        check("dn_dir", direction, 0);
        tick(TRAVEL);
        check("dn_floor2", {current_floor, moving}, {3'd2, 1'b1});
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_floor", current_floor, 0);
        check("mid_rst_flags", {moving, busy, door_open, direction}, 4'b0001);

        // Same-floor request at 5
        go(3'd5);
        wait_idle("to5_timeout");
        check("at5", current_floor, 5);
        go(3'd5);
        check("same_flags", {arrived, door_open, moving, direction}, 4'b1101);
        check("same_floor", current_floor, 5);
        wait_idle("same_timeout");

        // Retarget: 0 -> 6, changed to 4 at floor 2, ignore 1 at floor 3
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        go(3'd6);
        tick(2 * TRAVEL);
        check("rt_at2", current_floor, 2);
        go(3'd4);
        tick(TRAVEL - 1);
        check("rt_at3", {current_floor, moving}, {3'd3, 1'b1});
        go(3'd1);
        tick(TRAVEL - 1);
        check("rt_arrive4", {current_floor, arrived, door_open, moving}, {3'd4, 3'b110});
        wait_idle("rt_timeout");

        // Downward full run 7 -> 0
        go(3'd7);
        wait_idle("to7_timeout");
        check("at7", current_floor, 7);
        go(3'd0);
        check("full_dn_start", {direction, moving}, 2'b01);
        cnt = 0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            logic [2:0] prev;
            prev = current_floor;
            tick(1);
            cnt++;
            if (current_floor > prev) bad++;
            if (arrived) break;
        end
        check("full_dn_cycles", cnt, 7 * TRAVEL);
        check("full_dn_floor", current_floor, 0);
        check("full_dn_nowrap", bad, 0);
        tick(1);
        check("full_dn_pulse", arrived, 0);
        wait_idle("dn_timeout");

        // Out-of-range target on six-floor car
        t6_floor = 3'd6;
        t6_valid = 1'b1;
        tick(1);
        check("oor6", {d6_busy, d6_moving, d6_door}, 0);
        t6_floor = 3'd7;
        tick(1);
        check("oor7", {d6_busy, d6_moving, d6_door}, 0);
        t6_floor = 3'd5;
        tick(1);
        t6_valid = 1'b0;
        check("inr5", {d6_busy, d6_moving}, 2'b11);

`ifdef CAR_DOOR_HOLD_EN
        go(3'd1);
        tick(TRAVEL);
        check("hold_arrive", {current_floor, arrived}, {3'd1, 1'b1});
        door_hold = 1'b1;
        tick(10);
        check("hold_open", door_open, 1);
        door_hold = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            cnt++;
            if (!door_open) break;
        end
        check("hold_release", cnt, DWELL);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
